// File: rtl/ct_lsu_sd_ex2_pkg.sv
// Shared LSU store-data definitions: SDIQ sizing, SDID width, EX2 pairing FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ct_lsu_sd_ex2_pkg;

  localparam int LSIQ_ENTRY_DEF = 12;
  localparam int SDID_W         = 4;

  // Pairing state for boundary-crossing stores split into two passes
  typedef enum logic {
    SD_IDLE      = 1'b0,
    SD_WAIT_SECD = 1'b1
  } sd_fsm_t;

endpackage

// File: rtl/ct_lsu_sd_ex2_rot64.sv
// Byte rotator: rotates a 64-bit doubleword left by rot_sel bytes.
// Latency: combinational.
// Backpressure: none.
module ct_lsu_sd_rot64 (
  input  logic [63:0] data_in,
  input  logic [2:0]  rot_sel,
  output logic [63:0] data_out
);

  logic [127:0] dbl;

  // Shifting a doubled copy left and keeping the top half gives a rotate without a zero-shift corner
  always_comb begin
    dbl      = {data_in, data_in} << {rot_sel, 3'b000};
    data_out = dbl[127:64];
  end

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: clock runs when globally enabled and either module or local enable is set.
// Latency: enable sampled in the low phase, takes effect on the next rising edge.
// Backpressure: none.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic en_lat;

  // Enable latch is transparent while the clock is low so clk_out never glitches
  always_latch begin
    if (!clk_in)
      en_lat = (global_en && (module_en || local_en)) || external_en || pad_yy_icg_scan_en;
  end

  assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/ct_lsu_sd_ex2.sv
// Store-data EX2 stage: registers rotated store data/SDID and tracks boundary-store second halves.
// Latency: 1 cycle from EX1 valid to EX2 strobe; sdid_err pulses 1 cycle after the violating pass.
// Backpressure: none; flush kills the EX1 pass and drops any pending boundary store.
module ct_lsu_sd_ex2
  import ct_lsu_sd_ex2_pkg::*;
#(
  parameter int LSIQ_ENTRY = LSIQ_ENTRY_DEF
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              cp0_lsu_icg_en,
  input  logic              cp0_yy_clk_en,
  input  logic              pad_yy_icg_scan_en,
  input  logic              rtu_yy_xx_flush,
  input  logic              sd_ex1_inst_vld,
  input  logic [SDID_W-1:0] sd_ex1_sdid,
  input  logic              sd_ex1_boundary,
  input  logic              sd_ex1_secd,
  input  logic [63:0]       sd_ex1_data,
  input  logic [2:0]        sd_ex1_rot_sel,
  output logic              sd_ex2_inst_vld,
  output logic [SDID_W-1:0] sd_ex2_sdid,
  output logic [63:0]       sd_ex2_data,
  output logic              sd_ex2_data_cmplt,
  output logic              sd_ex2_first_half,
  output logic              sd_ex2_pend_vld,
  output logic [SDID_W-1:0] sd_ex2_pend_sdid,
  output logic              sd_ex2_sdid_err
);

  // An SDID must be able to name every queue entry
  if (LSIQ_ENTRY < 1 || LSIQ_ENTRY > (1 << SDID_W)) begin : g_bad_cfg
    $error("LSIQ_ENTRY does not fit the SDID width");
  end

  logic              accept;
  logic              sd_clk;
  logic [63:0]       rot_data;
  logic [SDID_W-1:0] sdid_q;
  logic [63:0]       data_q;
  logic              vld_q;
  logic              boundary_q;
  logic              secd_q;
  sd_fsm_t           state;
  logic [SDID_W-1:0] pend_sdid_q;
  logic              err_q;

  assign accept = sd_ex1_inst_vld && !rtu_yy_xx_flush;

  // Wide data/SDID flops only need a clock when EX1 carries a store
  gated_clk_cell x_sd_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_lsu_icg_en),
    .local_en           (sd_ex1_inst_vld),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (sd_clk)
  );

  ct_lsu_sd_rot64 x_sd_rot (
    .data_in  (sd_ex1_data),
    .rot_sel  (sd_ex1_rot_sel),
    .data_out (rot_data)
  );

  // Capture SDID and rotated data of accepted passes; hold otherwise
  always_ff @(posedge sd_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      sdid_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      sdid_q <= sd_ex1_sdid;
      data_q <= rot_data;
    end
  end

  // EX2 strobe and the pass-type bits that qualify it
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_q      <= 1'b0;
      boundary_q <= 1'b0;
      secd_q     <= 1'b0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        boundary_q <= sd_ex1_boundary;
        secd_q     <= sd_ex1_secd;
      end
    end
  end

  // Boundary-store pairing FSM; a second pass is checked against the recorded first-half SDID
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state       <= SD_IDLE;
      pend_sdid_q <= '0;
      err_q       <= 1'b0;
    end else if (rtu_yy_xx_flush) begin
      state <= SD_IDLE;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        case (state)
          SD_IDLE: begin
            if (sd_ex1_secd) begin
              err_q <= 1'b1;
            end else if (sd_ex1_boundary) begin
              state       <= SD_WAIT_SECD;
              pend_sdid_q <= sd_ex1_sdid;
            end
          end
          SD_WAIT_SECD: begin
            if (sd_ex1_secd) begin
              if (sd_ex1_sdid == pend_sdid_q)
                state <= SD_IDLE;
              else
                err_q <= 1'b1;
            end else if (sd_ex1_boundary) begin
              err_q       <= 1'b1;
              pend_sdid_q <= sd_ex1_sdid;
            end
          end
          default: state <= SD_IDLE;
        endcase
      end
    end
  end

  assign sd_ex2_inst_vld   = vld_q;
  assign sd_ex2_sdid       = sdid_q;
  assign sd_ex2_data       = data_q;
  assign sd_ex2_data_cmplt = vld_q && (!boundary_q || secd_q);
  assign sd_ex2_first_half = vld_q && boundary_q && !secd_q;
  assign sd_ex2_pend_vld   = (state == SD_WAIT_SECD);
  assign sd_ex2_pend_sdid  = pend_sdid_q;
  assign sd_ex2_sdid_err   = err_q;

endmodule

// File: tb/tb_ct_lsu_sd_ex2.sv
// Bench for the store-data EX2 stage: directed passes plus a random stream against a pairing model.
// Latency: outputs checked one cycle after each EX1 pass.
// Backpressure: none.
module tb_ct_lsu_sd_ex2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icg_en = 1'b0, clk_en = 1'b1, scan_en = 1'b0;
  logic        flush = 1'b0;
  logic        vld = 1'b0;
  logic [3:0]  sdid = '0;
  logic        bnd = 1'b0, secd = 1'b0;
  logic [63:0] data = '0;
  logic [2:0]  rot = '0;

  logic        o_vld, o_cmplt, o_first, o_pend, o_err;
  logic [3:0]  o_sdid, o_pend_sdid;
  logic [63:0] o_data;

  int n_checks = 0;
  int n_errors = 0;

  ct_lsu_sd_ex2 #(.LSIQ_ENTRY(12)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .cp0_lsu_icg_en     (icg_en),
    .cp0_yy_clk_en      (clk_en),
    .pad_yy_icg_scan_en (scan_en),
    .rtu_yy_xx_flush    (flush),
    .sd_ex1_inst_vld    (vld),
    .sd_ex1_sdid        (sdid),
    .sd_ex1_boundary    (bnd),
    .sd_ex1_secd        (secd),
    .sd_ex1_data        (data),
    .sd_ex1_rot_sel     (rot),
    .sd_ex2_inst_vld    (o_vld),
    .sd_ex2_sdid        (o_sdid),
    .sd_ex2_data        (o_data),
    .sd_ex2_data_cmplt  (o_cmplt),
    .sd_ex2_first_half  (o_first),
    .sd_ex2_pend_vld    (o_pend),
    .sd_ex2_pend_sdid   (o_pend_sdid),
    .sd_ex2_sdid_err    (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_vld = 0, m_cmplt = 0, m_first = 0, m_err = 0;
  logic [3:0]  m_sdid = 0;
  logic [63:0] m_data = 0;
  bit          m_pending = 0;
  logic [3:0]  m_pid = 0;

  function automatic logic [63:0] rotl_bytes(input logic [63:0] d, input int r);
    logic [63:0] o;
    for (int k = 0; k < 8; k++) o[((k + r) % 8) * 8 +: 8] = d[k * 8 +: 8];
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld = 0; m_cmplt = 0; m_first = 0; m_err = 0;
      m_sdid = 0; m_data = 0; m_pending = 0; m_pid = 0;
    end else begin
      bit acc;
      acc = vld && !flush;
      m_vld = acc;
      m_cmplt = acc && (!bnd || secd);
      m_first = acc && bnd && !secd;
      m_err = 0;
      if (acc) begin
        m_sdid = sdid;
        m_data = rotl_bytes(data, int'(rot));
      end
      if (flush) m_pending = 0;
      else if (acc) begin
        if (secd) begin
          if (m_pending && sdid == m_pid) m_pending = 0;
          else m_err = 1;
        end else if (bnd) begin
          if (m_pending) m_err = 1;
          m_pending = 1;
          m_pid = sdid;
        end
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    chk("m_vld", {63'd0, o_vld}, {63'd0, m_vld});
    chk("m_cmplt", {63'd0, o_cmplt}, {63'd0, m_cmplt});
    chk("m_first", {63'd0, o_first}, {63'd0, m_first});
    chk("m_err", {63'd0, o_err}, {63'd0, m_err});
    chk("m_pend_vld", {63'd0, o_pend}, {63'd0, m_pending});
    if (m_pending || !rst_n) chk("m_pend_sdid", {60'd0, o_pend_sdid}, {60'd0, m_pid});
    if (m_vld || !rst_n) begin
      chk("m_sdid", {60'd0, o_sdid}, {60'd0, m_sdid});
      chk("m_data", o_data, m_data);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic v, input logic [3:0] id, input logic b, input logic s,
                     input logic [63:0] d, input logic [2:0] r, input logic f);
    vld = v; sdid = id; bnd = b; secd = s; data = d; rot = r; flush = f;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 4'd0, 0, 0, 64'd0, 3'd0, 0);
  endtask

  localparam logic [63:0] D0 = 64'h0011_2233_4455_6677;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {63'd0, o_vld}, 64'd0);
    chk("rst_data", o_data, 64'd0);
    chk("rst_pend", {63'd0, o_pend}, 64'd0);
    chk("rst_err", {63'd0, o_err}, 64'd0);
    rst_n = 1'b1;
    idle();

    // plain store
    cyc(1, 4'd5, 0, 0, D0, 3'd2, 0);
    chk("plain_vld", {63'd0, o_vld}, 64'd1);
    chk("plain_sdid", {60'd0, o_sdid}, 64'd5);
    chk("plain_data", o_data, 64'h2233_4455_6677_0011);
    chk("plain_cmplt", {63'd0, o_cmplt}, 64'd1);
    chk("plain_pend", {63'd0, o_pend}, 64'd0);
    cyc(1, 4'd1, 0, 0, D0, 3'd7, 0);
    chk("rot7_data", o_data, 64'h7700_1122_3344_5566);
    cyc(1, 4'd2, 0, 0, D0, 3'd0, 0);
    chk("rot0_data", o_data, D0);
    idle();
    chk("idle_vld", {63'd0, o_vld}, 64'd0);
    chk("hold_data", o_data, D0);

    // boundary pair
    cyc(1, 4'd3, 1, 0, D0, 3'd1, 0);
    chk("pair_first", {63'd0, o_first}, 64'd1);
    chk("pair_nocmplt", {63'd0, o_cmplt}, 64'd0);
    chk("pair_pend", {63'd0, o_pend}, 64'd1);
    chk("pair_pend_sdid", {60'd0, o_pend_sdid}, 64'd3);
    cyc(1, 4'd3, 1, 1, D0, 3'd1, 0);
    chk("pair_cmplt", {63'd0, o_cmplt}, 64'd1);
    chk("pair_pend_clr", {63'd0, o_pend}, 64'd0);
    chk("pair_noerr", {63'd0, o_err}, 64'd0);
    idle();

    // interleaved plain store while waiting
    cyc(1, 4'd3, 1, 0, D0, 3'd0, 0);
    cyc(1, 4'd7, 0, 0, D0, 3'd0, 0);
    chk("intl_sdid", {60'd0, o_sdid}, 64'd7);
    chk("intl_cmplt", {63'd0, o_cmplt}, 64'd1);
    chk("intl_pend_sdid", {60'd0, o_pend_sdid}, 64'd3);
    cyc(1, 4'd3, 1, 1, D0, 3'd0, 0);
    chk("intl_done", {63'd0, o_pend}, 64'd0);
    chk("intl_noerr", {63'd0, o_err}, 64'd0);
    idle();

    // mismatched second half
    cyc(1, 4'd3, 1, 0, D0, 3'd0, 0);
    cyc(1, 4'd4, 1, 1, D0, 3'd0, 0);
    chk("mis_err", {63'd0, o_err}, 64'd1);
    chk("mis_pend_sdid", {60'd0, o_pend_sdid}, 64'd3);
    cyc(1, 4'd3, 1, 1, D0, 3'd0, 0);
    chk("mis_err_1cyc", {63'd0, o_err}, 64'd0);
    chk("mis_recover", {63'd0, o_pend}, 64'd0);
    idle();

    // second first-half while waiting overwrites the pending SDID
    cyc(1, 4'd3, 1, 0, D0, 3'd0, 0);
    cyc(1, 4'd6, 1, 0, D0, 3'd0, 0);
    chk("ovw_err", {63'd0, o_err}, 64'd1);
    chk("ovw_pend_sdid", {60'd0, o_pend_sdid}, 64'd6);
    cyc(1, 4'd6, 1, 1, D0, 3'd0, 0);
    chk("ovw_done", {63'd0, o_pend}, 64'd0);
    idle();

    // flush
    cyc(1, 4'd3, 1, 0, D0, 3'd0, 1);
    chk("fl_vld", {63'd0, o_vld}, 64'd0);
    chk("fl_idle", {63'd0, o_pend}, 64'd0);
    cyc(1, 4'd3, 1, 0, D0, 3'd0, 0);
    cyc(0, 4'd0, 0, 0, D0, 3'd0, 1);
    chk("fl_wait_drop", {63'd0, o_pend}, 64'd0);
    idle();

    // random stream against the model
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 11)), 1'($urandom), 1'($urandom),
          {$urandom, $urandom}, 3'($urandom), ($urandom_range(0, 9) == 0));
    end
    idle();

    // reset while waiting for the second half
    cyc(1, 4'd3, 1, 0, D0, 3'd4, 0);
    chk("rst_mid_pend", {63'd0, o_pend}, 64'd1);
    vld = 0; bnd = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", {63'd0, o_vld}, 64'd0);
    chk("rst_mid_first", {63'd0, o_first}, 64'd0);
    chk("rst_mid_pend0", {63'd0, o_pend}, 64'd0);
    chk("rst_mid_data", o_data, 64'd0);
    chk("rst_mid_err", {63'd0, o_err}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    cyc(1, 4'd3, 1, 1, D0, 3'd0, 0);
    chk("post_rst_err", {63'd0, o_err}, 64'd1);
    idle();
    chk("post_rst_err_1cyc", {63'd0, o_err}, 64'd0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ct_lsu_sd_ex2.md
CT_LSU_SD_EX2 -- requirements
Module: ct_lsu_sd_ex2

Interface
REQ-001 SHALL have parameter LSIQ_ENTRY, default 12, meaning the number of store-data issue queue entries; SDID width SHALL be 4.
REQ-002 SHALL have ports: forever_cpuclk  in  1  sole clock; cpurst_b  in  1  asynchronous active-low reset. These are the only clock and reset.
REQ-003 cp0_lsu_icg_en, cp0_yy_clk_en, pad_yy_icg_scan_en  in  1 each  clock-gating controls.
REQ-004 rtu_yy_xx_flush  in  1  pipeline flush.
REQ-005 sd_ex1_inst_vld  in  1  store-data valid in EX1.
REQ-006 sd_ex1_sdid  in  4  encoded SDIQ entry.
REQ-007 sd_ex1_boundary  in  1  store crosses an 8-byte boundary.
REQ-008 sd_ex1_secd  in  1  second-half pass of a boundary store.
REQ-009 sd_ex1_data  in  64  raw store data.
REQ-010 sd_ex1_rot_sel  in  3  byte-rotate amount from the store queue.
REQ-011 sd_ex2_inst_vld  out  1  EX2 write strobe to the store queue.
REQ-012 sd_ex2_sdid  out  4  EX2 SDID.
REQ-013 sd_ex2_data  out  64  rotated store data.
REQ-014 sd_ex2_data_cmplt  out  1  entry data now complete.
REQ-015 sd_ex2_first_half  out  1  first pass of a boundary store.
REQ-016 sd_ex2_pend_vld  out  1  a boundary store is awaiting its second half.
REQ-017 sd_ex2_pend_sdid  out  4  SDID awaiting its second half.
REQ-018 sd_ex2_sdid_err  out  1  one-cycle protocol-violation pulse.

Function
REQ-019 Define accept = sd_ex1_inst_vld && !rtu_yy_xx_flush.
REQ-020 sd_ex2_inst_vld SHALL equal accept registered on the next clock edge (1-cycle latency).
REQ-021 When accept is 1, the block SHALL register sd_ex2_sdid and sd_ex2_data on the next clock edge; otherwise both SHALL hold their values.
- Registered sd_ex2_data value = sd_ex1_data rotated left by 8*sd_ex1_rot_sel bits (rot_sel=0 means no change).
REQ-022 sd_ex2_data_cmplt = sd_ex2_inst_vld && (!boundary || secd), using the registered EX2 copies of boundary and secd.
REQ-023 sd_ex2_first_half = sd_ex2_inst_vld && boundary && !secd, using the registered EX2 copies; cmplt and first_half SHALL never both be 1.
REQ-024 The block SHALL have a two-state FSM with states IDLE and WAIT_SECD, updated on accept; sd_ex2_pend_vld SHALL be 1 exactly in WAIT_SECD.
REQ-025 In IDLE, on accept && boundary && !secd: go to WAIT_SECD and set pend_sdid = sd_ex1_sdid.
REQ-026 In IDLE, on accept && secd: pulse sdid_err in the next cycle and stay in IDLE.
REQ-027 In WAIT_SECD, on accept && secd && sdid==pend_sdid: go to IDLE.
REQ-028 In WAIT_SECD, on accept && secd && sdid!=pend_sdid: pulse sdid_err and keep the state and pend_sdid unchanged.
REQ-029 In WAIT_SECD, on accept && boundary && !secd: pulse sdid_err, overwrite pend_sdid with the new SDID, and stay in WAIT_SECD.
REQ-030 In WAIT_SECD, an accept with !boundary (any SDID) is legal: it completes normally and does not change the state.
REQ-031 rtu_yy_xx_flush SHALL force the FSM to IDLE on the next clock edge and suppress sd_ex2_inst_vld and sdid_err; flush wins over a simultaneous valid.
REQ-032 sdid_err SHALL be registered and last exactly one cycle per violation.

Reset
REQ-033 While cpurst_b=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and all data, SDID and pend registers SHALL be 0.
REQ-034 Reset during WAIT_SECD SHALL drop the pending state with no error pulse.

Structure
REQ-035 The block SHALL use one gated_clk_cell for the data and SDID registers, with local_en = sd_ex1_inst_vld; the control and FSM flops SHALL run on forever_cpuclk.
REQ-036 FSM state encodings, LSIQ_ENTRY and the SDID width SHALL live in the shared LSU package.
REQ-037 The byte rotator SHALL be one sub-module, ct_lsu_sd_rot64, which is purely combinational.

Verification
REQ-038 Plain store: vld, sdid=5, boundary=0, data=0x0011223344556677, rot=2 -> next cycle: ex2_vld=1, sdid=5, data=0x2233445566770011, cmplt=1, pend_vld=0.
REQ-039 Boundary pair: first pass sdid=3 (boundary=1, secd=0), then second pass sdid=3 (secd=1) -> first_half then cmplt; pend_vld=1 for exactly one cycle; no error.
REQ-040 Interleave: boundary first half sdid=3, then plain store sdid=7, then secd sdid=3 -> the sdid=7 entry completes; pend_sdid stays 3 until the secd pass; no error.
REQ-041 Error: WAIT_SECD with pend=3 receives secd sdid=4 -> sdid_err pulses 1 cycle, pend stays 3; a subsequent secd sdid=3 completes.
REQ-042 Flush: valid boundary first half arrives together with flush -> ex2_vld=0 and FSM IDLE; flush while in WAIT_SECD -> pend_vld=0 next cycle.
REQ-043 Reset mid-operation: assert cpurst_b=0 in WAIT_SECD -> all outputs 0 immediately; after release, a secd pass raises sdid_err.
